// File: rtl/set_feeder.sv
// Job FIFO and launch sequencer in front of the set-count engine.
// One job in flight; results are held until the host takes them.
module set_feeder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 96
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_central,
  input  logic [11:0] in_radius,
  input  logic [1:0]  in_mode,
  input  logic [3:0]  in_tag,
  output logic        set_en,
  output logic [23:0] set_central,
  output logic [11:0] set_radius,
  output logic [1:0]  set_mode,
  input  logic        set_busy,
  input  logic        set_valid,
  input  logic [7:0]  set_candidate,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_candidate,
  output logic [3:0]  out_tag,
  output logic        out_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef struct packed {
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
    logic [3:0]  tag;
  } job_t;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    RUN,
    DRAIN
  } state_t;

  job_t        mem [DEPTH];
  job_t        head;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        bad_mode;

  state_t      state;
  logic [7:0]  tmo;
  logic [3:0]  cur_tag;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign bad_mode = (head.mode == 2'b11);

  // Illegal jobs retire straight from IDLE without waiting on the engine.
  assign pop = (state == IDLE) && !empty && !out_valid &&
               (bad_mode || !set_busy);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= {in_central, in_radius, in_mode, in_tag};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      tmo           <= '0;
      cur_tag       <= '0;
      set_en        <= 1'b0;
      set_central   <= '0;
      set_radius    <= '0;
      set_mode      <= '0;
      out_valid     <= 1'b0;
      out_candidate <= '0;
      out_tag       <= '0;
      out_err       <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            if (bad_mode) begin
              out_candidate <= 8'h00;
              out_tag       <= head.tag;
              out_err       <= 1'b1;
              out_valid     <= 1'b1;
            end else begin
              set_en      <= 1'b1;
              set_central <= head.central;
              set_radius  <= head.radius;
              set_mode    <= head.mode;
              cur_tag     <= head.tag;
              tmo         <= '0;
              state       <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          set_en <= 1'b0;
          tmo    <= '0;
          state  <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tmo == TMO) begin
            out_candidate <= 8'hFF;
            out_tag       <= cur_tag;
            out_err       <= 1'b1;
            out_valid     <= 1'b1;
            state         <= DRAIN;
          end else begin
            tmo <= tmo + 8'd1;
            if (set_busy) state <= RUN;
          end
        end
        RUN: begin
          if (set_valid) begin
            out_candidate <= set_candidate;
            out_tag       <= cur_tag;
            out_err       <= 1'b0;
            out_valid     <= 1'b1;
            state         <= DRAIN;
          end else if (tmo == TMO) begin
            out_candidate <= 8'hFF;
            out_tag       <= cur_tag;
            out_err       <= 1'b1;
            out_valid     <= 1'b1;
            state         <= DRAIN;
          end else begin
            tmo <= tmo + 8'd1;
          end
        end
        DRAIN: begin
          if (!set_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_set_feeder.sv
// Directed bench for set_feeder with a behavioural set-count engine.
// Engine: busy the cycle after set_en, result strobe 64 cycles later.
module tb_set_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_central;
  logic [11:0] in_radius;
  logic [1:0]  in_mode;
  logic [3:0]  in_tag;
  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        set_busy;
  logic        set_valid;
  logic [7:0]  set_candidate;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_candidate;
  logic [3:0]  out_tag;
  logic        out_err;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int en_cyc = 0;
  int en_cnt = 0;

  bit         eng_hang = 1'b0;
  logic       hung;
  int         eng_k;

  always #5 clk = ~clk;

  set_feeder #(.DEPTH(4), .TIMEOUT(96)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_central(in_central),
    .in_radius(in_radius),
    .in_mode(in_mode),
    .in_tag(in_tag),
    .set_en(set_en),
    .set_central(set_central),
    .set_radius(set_radius),
    .set_mode(set_mode),
    .set_busy(set_busy),
    .set_valid(set_valid),
    .set_candidate(set_candidate),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_candidate(out_candidate),
    .out_tag(out_tag),
    .out_err(out_err)
  );

  function automatic logic [7:0] eng_model(input logic [23:0] c,
                                           input logic [11:0] r);
    if (c == 24'h440000 && r == 12'h200) return 8'd13;
    return c[7:0];
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (set_en) begin
      en_cyc <= cyc;
      en_cnt <= en_cnt + 1;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      set_busy      <= 1'b0;
      set_valid     <= 1'b0;
      set_candidate <= '0;
      hung          <= 1'b0;
      eng_k         <= 0;
    end else begin
      set_valid <= 1'b0;
      if (set_en) begin
        set_busy      <= 1'b1;
        eng_k         <= 0;
        hung          <= eng_hang;
        set_candidate <= eng_model(set_central, set_radius);
      end else if (set_busy) begin
        if (hung) begin
          if (!eng_hang) set_busy <= 1'b0;
        end else begin
          eng_k <= eng_k + 1;
          if (eng_k == 63) set_valid <= 1'b1;
          if (set_valid) set_busy <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic push_job(input logic [23:0] c, input logic [11:0] r,
                          input logic [1:0] m, input logic [3:0] t);
    int k;
    in_central = c;
    in_radius  = r;
    in_mode    = m;
    in_tag     = t;
    in_valid   = 1'b1;
    k = 0;
    while (!in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("push_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int bound, output int at);
    int k;
    k = 0;
    while (!out_valid && k < bound) begin
      @(negedge clk);
      k++;
    end
    at = cyc;
    chk("wait_out_valid", out_valid, 1);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("accept_clears", out_valid, 0);
  endtask

  initial begin
    int at;
    int e0;
    bit seen;
    bit stable;
    logic [7:0] c0;
    logic [3:0] t0;
    logic       r0;

    rst        = 1'b0;
    in_valid   = 1'b0;
    in_central = '0;
    in_radius  = '0;
    in_mode    = '0;
    in_tag     = '0;
    out_ready  = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_set_en", set_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_cand", out_candidate, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_set_central", set_central, 0);
    chk("rst_set_radius", set_radius, 0);
    chk("rst_set_mode", set_mode, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // nominal job
    push_job(24'h440000, 12'h200, 2'b00, 4'd3);
    wait_out(200, at);
    chk("nom_latency", at - en_cyc, 66);
    chk("nom_en_pulses", en_cnt, 1);
    chk("nom_cand", out_candidate, 13);
    chk("nom_tag", out_tag, 3);
    chk("nom_err", out_err, 0);

    // held result stays stable and blocks launches
    push_job(24'h000031, 12'h001, 2'b01, 4'd2);
    c0 = out_candidate;
    t0 = out_tag;
    r0 = out_err;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || out_candidate !== c0 || out_tag !== t0 ||
          out_err !== r0) stable = 1'b0;
    end
    chk("hold_stable", stable, 1);
    chk("hold_no_launch", en_cnt, 1);
    accept();
    wait_out(200, at);
    chk("held_job_tag", out_tag, 2);
    chk("held_job_cand", out_candidate, 8'h31);
    accept();

    // illegal mode
    e0 = en_cnt;
    push_job(24'h123456, 12'h111, 2'b11, 4'd9);
    wait_out(2, at);
    chk("bad_cand", out_candidate, 0);
    chk("bad_tag", out_tag, 9);
    chk("bad_err", out_err, 1);
    chk("bad_no_en", en_cnt, e0);
    accept();

    // DEPTH+1 jobs back to back
    e0 = en_cnt;
    for (int i = 1; i <= 5; i++)
      push_job(24'(8'h10 + i), 12'h010, 2'b10, 4'(i));
    chk("fifo_full", in_ready, 0);
    wait_out(200, at);
    repeat (5) @(negedge clk);
    chk("fifo_one_launch", en_cnt, e0 + 1);
    chk("fifo_still_full", in_ready, 0);
    for (int i = 1; i <= 5; i++) begin
      wait_out(200, at);
      chk("order_tag", out_tag, i);
      chk("order_cand", out_candidate, 8'h10 + i);
      chk("order_err", out_err, 0);
      accept();
    end
    chk("fifo_total_launch", en_cnt, e0 + 5);

    // engine never answers
    eng_hang = 1'b1;
    e0 = en_cnt;
    push_job(24'h000026, 12'h020, 2'b00, 4'd6);
    wait_out(300, at);
    chk("tmo_latency", at - en_cyc, 98);
    chk("tmo_cand", out_candidate, 8'hFF);
    chk("tmo_err", out_err, 1);
    chk("tmo_tag", out_tag, 6);
    accept();
    push_job(24'h000027, 12'h020, 2'b10, 4'd7);
    repeat (10) @(negedge clk);
    chk("tmo_wait_busy", en_cnt, e0 + 1);
    eng_hang = 1'b0;
    wait_out(300, at);
    chk("post_tmo_tag", out_tag, 7);
    chk("post_tmo_cand", out_candidate, 8'h27);
    chk("post_tmo_err", out_err, 0);
    chk("post_tmo_en", en_cnt, e0 + 2);
    accept();

    // reset in the middle of a run
    push_job(24'h000028, 12'h020, 2'b00, 4'd8);
    push_job(24'h00002A, 12'h020, 2'b00, 4'd10);
    repeat (20) @(negedge clk);
    chk("pre_rst_busy", set_busy, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_set_en", set_en, 0);
    chk("mid_rst_central", set_central, 0);
    chk("mid_rst_radius", set_radius, 0);
    chk("mid_rst_mode", set_mode, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_cand", out_candidate, 0);
    chk("mid_rst_tag", out_tag, 0);
    chk("mid_rst_err", out_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    e0 = en_cnt;
    seen = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("no_stale_result", seen, 0);
    chk("no_stale_launch", en_cnt, e0);
    chk("rst_fifo_empty", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
